// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin sharing of a single bin2bcd converter among NREQ clients.
// Optional watchdog on the converter handshake is enabled by defining BCD_ARB_TIMEOUT_EN.
`default_nettype none

module bcd_conv_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_bin,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [31:0]          result_dn,
  output logic [31:0]          result_up,
  output logic                 busy,
  output logic                 conv_init,
  output logic [31:0]          conv_bin,
  input  logic                 conv_ready,
  input  logic [31:0]          conv_dn,
  input  logic [31:0]          conv_up
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            win_any;
  logic [31:0]     win_bin;
  logic            wd_expired;

  // Rotating priority: the search starts one past the last winner.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!win_any && req[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    win_bin = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_bin = req_bin[32*i +: 32];
      end
    end
  end

`ifdef BCD_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        err_q;

  assign wd_expired = (wd_cnt >= 16'(TIMEOUT_CYC - 1));

  // Counter restarts on entry to each wait phase; err_q remembers an abort until DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_any) begin
            err_q <= 1'b0;
          end
        end
        S_LAUNCH: begin
          wd_cnt <= '0;
        end
        S_WAIT_LO: begin
          if (!conv_ready) begin
            wd_cnt <= '0;
          end else if (wd_expired) begin
            err_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        S_WAIT_HI: begin
          if (!conv_ready) begin
            if (wd_expired) begin
              err_q <= 1'b1;
            end else begin
              wd_cnt <= wd_cnt + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign err = (state == S_DONE) && err_q;
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (win_any) begin
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: state_nxt = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!conv_ready) begin
          state_nxt = S_WAIT_HI;
        end else if (wd_expired) begin
          state_nxt = S_DONE;
        end
      end
      S_WAIT_HI: begin
        if (conv_ready || wd_expired) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign conv_init = (state == S_LAUNCH);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE) ? gnt : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= IW'(NREQ - 1);
      sel_idx   <= '0;
      gnt       <= '0;
      conv_bin  <= '0;
      result_dn <= '0;
      result_up <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (win_any) begin
            sel_idx  <= win_idx;
            gnt      <= NREQ'(1) << win_idx;
            conv_bin <= win_bin;
          end
        end
        S_WAIT_LO: begin
          if (conv_ready && wd_expired) begin
            result_dn <= '0;
            result_up <= '0;
          end
        end
        S_WAIT_HI: begin
          if (conv_ready) begin
            result_dn <= conv_dn;
            result_up <= conv_up;
          end else if (wd_expired) begin
            result_dn <= '0;
            result_up <= '0;
          end
        end
        S_DONE: begin
          ptr <= sel_idx;
          gnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: randomized self-checking bench with a behavioural bin2bcd model.
`default_nettype none

module tb_bcd_conv_arbiter;
  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*32-1:0]   req_bin;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic                 err;
  logic [31:0]          result_dn;
  logic [31:0]          result_up;
  logic                 busy;
  logic                 conv_init;
  logic [31:0]          conv_bin;
  logic                 conv_ready;
  logic [31:0]          conv_dn;
  logic [31:0]          conv_up;

  int errors = 0;
  int checks = 0;
  int exp_ptr = NREQ - 1;
  logic stuck = 1'b0;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .reset(reset), .req(req), .req_bin(req_bin),
    .gnt(gnt), .done(done), .err(err),
    .result_dn(result_dn), .result_up(result_up),
    .busy(busy), .conv_init(conv_init), .conv_bin(conv_bin),
    .conv_ready(conv_ready), .conv_dn(conv_dn), .conv_up(conv_up)
  );

  function automatic logic [63:0] to_bcd(input logic [31:0] v);
    logic [63:0] r;
    longint unsigned x;
    r = '0;
    x = longint'(v);
    for (int d = 0; d < 16; d++) begin
      r = r | (64'(x % 10) << (4 * d));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (((m >> ((p + k) % NREQ)) & NREQ'(1)) != 0) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Behavioural converter: ready drops after init, rises with the result some cycles later.
  logic        m_run;
  int          m_cnt;
  logic [63:0] m_val;
  int          reinit_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      conv_ready <= 1'b1;
      m_run      <= 1'b0;
      m_cnt      <= 0;
      m_val      <= '0;
      conv_dn    <= '0;
      conv_up    <= '0;
    end else begin
      if (conv_init && m_run) reinit_cnt <= reinit_cnt + 1;
      if (conv_init && !stuck) begin
        conv_ready <= 1'b0;
        m_run      <= 1'b1;
        m_cnt      <= int'($urandom_range(30, 8));
        m_val      <= to_bcd(conv_bin);
      end else if (m_run) begin
        if (m_cnt == 0) begin
          conv_ready <= 1'b1;
          m_run      <= 1'b0;
          conv_dn    <= m_val[31:0];
          conv_up    <= m_val[63:32];
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output logic [NREQ-1:0] d, output logic [NREQ-1:0] first_g,
                           output int inits, output bit multi, output int g_cyc, output int d_cyc);
    d = '0; first_g = '0; inits = 0; multi = 1'b0; g_cyc = -1; d_cyc = -1;
    for (int c = 0; c < limit; c++) begin
      tick();
      if (conv_init) inits++;
      if ($countones(gnt) > 1) multi = 1'b1;
      if (first_g == '0 && gnt != '0) begin
        first_g = gnt;
        g_cyc = c;
      end
      if (done != '0) begin
        d = done;
        d_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; req_bin = '0;
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++; if (done !== '0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (conv_init !== 1'b0) begin errors++; $display("FAIL reset_init: got %b want 0", conv_init); end
    checks++; if (result_dn !== '0 || result_up !== '0) begin errors++;
      $display("FAIL reset_result: got %h/%h want 0/0", result_up, result_dn); end
    checks++; if (conv_bin !== '0) begin errors++; $display("FAIL reset_conv_bin: got %h want 0", conv_bin); end
    reset = 1'b0;
    exp_ptr = NREQ - 1;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] d, fg; int inits, gc, dc; bit multi;
    req_bin[31:0] = 32'd1234;
    req = 4'b0001;
    wait_done(500, d, fg, inits, multi, gc, dc);
    checks++; if (fg !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", fg); end
    checks++; if (inits !== 1) begin errors++; $display("FAIL single_init_pulses: got %0d want 1", inits); end
    checks++; if (d !== 4'b0001) begin errors++; $display("FAIL single_done: got %b want 0001", d); end
    checks++; if (result_dn !== 32'h0000_1234 || result_up !== 32'h0) begin errors++;
      $display("FAIL single_result: got %h/%h want 00000000/00001234", result_up, result_dn); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err); end
    req = '0;
    exp_ptr = 0;
    tick();
    checks++; if (done !== '0 || gnt !== '0) begin errors++;
      $display("FAIL single_release: got done=%b gnt=%b want 0/0", done, gnt); end
  endtask

  task automatic test_max();
    logic [NREQ-1:0] d, fg; int inits, gc, dc; bit multi;
    req_bin[63:32] = 32'hFFFF_FFFF;
    req = 4'b0010;
    wait_done(500, d, fg, inits, multi, gc, dc);
    checks++; if (d !== 4'b0010) begin errors++; $display("FAIL max_done: got %b want 0010", d); end
    checks++; if (result_dn !== 32'h9496_7295 || result_up !== 32'h0000_0042) begin errors++;
      $display("FAIL max_result: got %h/%h want 00000042/94967295", result_up, result_dn); end
    req = '0;
    exp_ptr = 1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] d, fg; int inits, gc, dc; bit multi;
    logic [31:0] ops [NREQ];
    logic [63:0] e;
    int order [5] = '{0, 1, 2, 3, 0};
    reset = 1'b1; tick(); reset = 1'b0;
    exp_ptr = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      ops[i] = ($urandom & 32'hFFFF_FFF0) | 32'(i);
      req_bin[32*i +: 32] = ops[i];
    end
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_done(500, d, fg, inits, multi, gc, dc);
      e = to_bcd(ops[order[n]]);
      checks++; if (d !== (NREQ'(1) << order[n])) begin errors++;
        $display("FAIL rr_order[%0d]: got %b want client %0d", n, d, order[n]); end
      checks++; if ({result_up, result_dn} !== e) begin errors++;
        $display("FAIL rr_result[%0d]: got %h want %h", n, {result_up, result_dn}, e); end
      checks++; if (multi !== 1'b0) begin errors++; $display("FAIL rr_onehot[%0d]: got multi-hot gnt want one-hot", n); end
      exp_ptr = order[n];
      if (n == 4) req = '0;
    end
    tick();
  endtask

  task automatic test_drop_req();
    logic [NREQ-1:0] d, fg; int inits, gc, dc; bit multi;
    logic [31:0] op;
    op = $urandom;
    req_bin[95:64] = op;
    req = 4'b0100;
    for (int c = 0; c < 20 && gnt == '0; c++) tick();
    repeat (5) tick();
    req = '0;
    req_bin[95:64] = ~op;
    wait_done(500, d, fg, inits, multi, gc, dc);
    checks++; if (d !== 4'b0100) begin errors++; $display("FAIL drop_done: got %b want 0100", d); end
    checks++; if ({result_up, result_dn} !== to_bcd(op)) begin errors++;
      $display("FAIL drop_result: got %h want %h", {result_up, result_dn}, to_bcd(op)); end
    exp_ptr = 2;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] d, fg; int inits, gc, dc; bit multi;
    logic [31:0] op;
    bit seen;
    req_bin[127:96] = $urandom;
    req = 4'b1000;
    for (int c = 0; c < 50 && !(busy && conv_ready == 1'b0); c++) tick();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || gnt !== '0 || conv_init !== 1'b0 || done !== '0) begin errors++;
      $display("FAIL midreset_outputs: got busy=%b gnt=%b init=%b done=%b want all 0", busy, gnt, conv_init, done); end
    reset = 1'b0;
    req = '0;
    exp_ptr = NREQ - 1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done != '0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_done: got a done pulse want none"); end
    op = $urandom;
    req_bin[127:96] = op;
    req = 4'b1000;
    wait_done(500, d, fg, inits, multi, gc, dc);
    checks++; if (d !== 4'b1000 || {result_up, result_dn} !== to_bcd(op)) begin errors++;
      $display("FAIL midreset_recover: got done=%b res=%h want 1000 %h", d, {result_up, result_dn}, to_bcd(op)); end
    req = '0;
    exp_ptr = 3;
    tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] d, fg, m; int inits, gc, dc, w; bit multi;
    logic [31:0] ops [NREQ];
    for (int it = 0; it < 16; it++) begin
      m = NREQ'($urandom_range((1 << NREQ) - 1, 1));
      for (int i = 0; i < NREQ; i++) begin
        ops[i] = $urandom;
        req_bin[32*i +: 32] = ops[i];
      end
      w = pick(m, exp_ptr);
      req = m;
      wait_done(500, d, fg, inits, multi, gc, dc);
      checks++; if (d !== (NREQ'(1) << w) || multi !== 1'b0 || inits !== 1) begin errors++;
        $display("FAIL rand_grant[%0d]: got done=%b multi=%b inits=%0d want client %0d", it, d, multi, inits, w); end
      checks++; if ({result_up, result_dn} !== to_bcd(ops[w]) || err !== 1'b0) begin errors++;
        $display("FAIL rand_result[%0d]: got %h err=%b want %h", it, {result_up, result_dn}, err, to_bcd(ops[w])); end
      exp_ptr = w;
      req = '0;
      repeat ($urandom_range(3, 1)) tick();
    end
  endtask

`ifdef BCD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [NREQ-1:0] d, fg; int inits, gc, dc; bit multi;
    logic [31:0] op;
    stuck = 1'b1;
    req_bin[31:0] = $urandom;
    req = 4'b0001;
    wait_done(300, d, fg, inits, multi, gc, dc);
    checks++; if (d !== 4'b0001 || err !== 1'b1) begin errors++;
      $display("FAIL timeout_done: got done=%b err=%b want 0001 err=1", d, err); end
    checks++; if (result_dn !== '0 || result_up !== '0) begin errors++;
      $display("FAIL timeout_result: got %h/%h want 0/0", result_up, result_dn); end
    checks++; if ((dc - gc) < 19 || (dc - gc) > 23) begin errors++;
      $display("FAIL timeout_latency: got %0d cycles want 19..23", dc - gc); end
    stuck = 1'b0;
    req = '0;
    exp_ptr = 0;
    tick();
    op = $urandom;
    req_bin[31:0] = op;
    req = 4'b0001;
    wait_done(500, d, fg, inits, multi, gc, dc);
    checks++; if (d !== 4'b0001 || err !== 1'b0 || {result_up, result_dn} !== to_bcd(op)) begin errors++;
      $display("FAIL timeout_recover: got done=%b err=%b res=%h want 0001 0 %h", d, err, {result_up, result_dn}, to_bcd(op)); end
    req = '0;
    tick();
  endtask
`endif

  task automatic test_no_reinit();
    checks++; if (reinit_cnt !== 0) begin errors++;
      $display("FAIL no_reinit: got %0d init pulses while converter busy want 0", reinit_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    req_bin = '0;
    test_reset();
    test_single();
    test_max();
    test_round_robin();
    test_drop_req();
    test_reset_mid();
    test_random();
`ifdef BCD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_no_reinit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
